// File: rtl/wash_phase_timer.sv
// ============================================================================
// Module   : wash_phase_timer
// Brief    : Times the fill/heat/wash/rinse/spin phases of a washer controller
//            and raises a registered "phase elapsed" flag for the active phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wash_phase_timer #(
    parameter int       CNT_WIDTH        = 8,
    parameter int       FILL_CYCLES      = 3,
    parameter int       HEAT_CYCLES      = 3,
    parameter int       WASH_CYCLES      = 6,
    parameter int       RINSE_CYCLES     = 3,
    parameter int       SPIN_CYCLES      = 3,
    parameter bit [2:0] STATE_FILL_WATER = 3'd2,
    parameter bit [2:0] STATE_HEAT_WATER = 3'd3,
    parameter bit [2:0] STATE_WASH       = 3'd4,
    parameter bit [2:0] STATE_RINSE      = 3'd5,
    parameter bit [2:0] STATE_SPIN       = 3'd6
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [2:0]           state,
    input  logic                 pause,
    output logic                 sig_Full,
    output logic                 sig_Temperature,
    output logic                 sig_Completed,
    output logic                 sig_Rinsed,
    output logic                 sig_Spun,
    output logic [CNT_WIDTH-1:0] remaining,
    output logic                 busy
);

    localparam int MAX_DUR = (2 ** CNT_WIDTH) - 1;

    // Reject durations the counter cannot represent, or that would never elapse.
    if (FILL_CYCLES  < 1 || FILL_CYCLES  > MAX_DUR ||
        HEAT_CYCLES  < 1 || HEAT_CYCLES  > MAX_DUR ||
        WASH_CYCLES  < 1 || WASH_CYCLES  > MAX_DUR ||
        RINSE_CYCLES < 1 || RINSE_CYCLES > MAX_DUR ||
        SPIN_CYCLES  < 1 || SPIN_CYCLES  > MAX_DUR) begin : g_dur_check
        $error("wash_phase_timer: every phase duration must be in 1..%0d", MAX_DUR);
    end

    localparam logic [CNT_WIDTH-1:0] FILL_DUR  = CNT_WIDTH'(FILL_CYCLES);
    localparam logic [CNT_WIDTH-1:0] HEAT_DUR  = CNT_WIDTH'(HEAT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] WASH_DUR  = CNT_WIDTH'(WASH_CYCLES);
    localparam logic [CNT_WIDTH-1:0] RINSE_DUR = CNT_WIDTH'(RINSE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] SPIN_DUR  = CNT_WIDTH'(SPIN_CYCLES);

    logic [2:0]           state_q;
    logic [CNT_WIDTH-1:0] cnt;
    logic [4:0]           sig_q;     // {spun, rinsed, completed, temperature, full}
    logic                 entry;
    logic                 timed;
    logic [CNT_WIDTH-1:0] dur;
    logic [4:0]           phase_sel;

    assign entry = (state != state_q);

    always_comb begin
        timed     = 1'b1;
        dur       = '0;
        phase_sel = 5'b00000;
        case (state_q)
            STATE_FILL_WATER: begin dur = FILL_DUR;  phase_sel = 5'b00001; end
            STATE_HEAT_WATER: begin dur = HEAT_DUR;  phase_sel = 5'b00010; end
            STATE_WASH:       begin dur = WASH_DUR;  phase_sel = 5'b00100; end
            STATE_RINSE:      begin dur = RINSE_DUR; phase_sel = 5'b01000; end
            STATE_SPIN:       begin dur = SPIN_DUR;  phase_sel = 5'b10000; end
            default:          timed = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= 3'd0;
            cnt     <= '0;
            sig_q   <= 5'b00000;
        end else begin
            state_q <= state;
            if (entry || !timed) begin
                cnt   <= '0;
                sig_q <= 5'b00000;
            end else if (!pause && (cnt < dur)) begin
                cnt <= cnt + 1'b1;
                // Flag rises on the same edge the count reaches its duration.
                if (cnt == dur - 1'b1) begin
                    sig_q <= phase_sel;
                end
            end
        end
    end

    assign sig_Full        = sig_q[0];
    assign sig_Temperature = sig_q[1];
    assign sig_Completed   = sig_q[2];
    assign sig_Rinsed      = sig_q[3];
    assign sig_Spun        = sig_q[4];

    assign remaining = (timed && !entry) ? (dur - cnt) : '0;
    assign busy      = timed && !entry && (cnt < dur);

endmodule

`default_nettype wire

// File: tb/tb_wash_phase_timer.sv
// ============================================================================
// Module   : tb_wash_phase_timer
// Brief    : Directed self-checking bench for wash_phase_timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wash_phase_timer;

    logic       clock;
    logic       reset_n;
    logic [2:0] state;
    logic       pause;

    logic       full_a, temp_a, comp_a, rins_a, spun_a, busy_a;
    logic [7:0] rem_a;
    logic       full_b, temp_b, comp_b, rins_b, spun_b, busy_b;
    logic [3:0] rem_b;

    int tests = 0;
    int fails = 0;

    wash_phase_timer dut (
        .clock(clock), .reset_n(reset_n), .state(state), .pause(pause),
        .sig_Full(full_a), .sig_Temperature(temp_a), .sig_Completed(comp_a),
        .sig_Rinsed(rins_a), .sig_Spun(spun_a), .remaining(rem_a), .busy(busy_a)
    );

    // Narrow counter at its largest legal wash duration, sharing the same stimulus.
    wash_phase_timer #(.CNT_WIDTH(4), .WASH_CYCLES(15)) dut_sat (
        .clock(clock), .reset_n(reset_n), .state(state), .pause(pause),
        .sig_Full(full_b), .sig_Temperature(temp_b), .sig_Completed(comp_b),
        .sig_Rinsed(rins_b), .sig_Spun(spun_b), .remaining(rem_b), .busy(busy_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] sigs_a();
        return {spun_a, rins_a, comp_a, temp_a, full_a};
    endfunction

    initial begin
        reset_n = 1'b0;
        state   = 3'd0;
        pause   = 1'b0;
        #1;
        chk("reset_sigs", 32'(sigs_a()), 0);
        chk("reset_rem", 32'(rem_a), 0);
        chk("reset_busy", 32'(busy_a), 0);
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();
        chk("idle_all", {sigs_a(), rem_a, busy_a}, 0);

        // Fill from idle: remaining 3,2,1,0 and flag after the third counting edge.
        state = 3'd2;
        chk("fill_pending_rem", 32'(rem_a), 0);
        tick();
        chk("fill_e0_rem", 32'(rem_a), 3);
        chk("fill_e0_busy", 32'(busy_a), 1);
        tick();
        chk("fill_e1_rem", 32'(rem_a), 2);
        tick();
        chk("fill_e2_rem", 32'(rem_a), 1);
        chk("fill_e2_sig", 32'(full_a), 0);
        tick();
        chk("fill_e3_rem", 32'(rem_a), 0);
        chk("fill_e3_sig", 32'(sigs_a()), 32'b00001);
        chk("fill_e3_busy", 32'(busy_a), 0);
        tick();
        chk("fill_hold_sig", 32'(full_a), 1);
        state = 3'd0;
        tick();
        chk("fill_exit_sig", 32'(sigs_a()), 0);

        // Wash with a 4-cycle pause after two counting edges.
        state = 3'd4;
        tick(); tick(); tick();
        chk("wash_e2_rem", 32'(rem_a), 4);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wash_pause_rem", 32'(rem_a), 4);
            chk("wash_pause_busy", 32'(busy_a), 1);
            chk("wash_pause_sig", 32'(comp_a), 0);
        end
        pause = 1'b0;
        tick(); tick(); tick();
        chk("wash_e9_rem", 32'(rem_a), 1);
        chk("wash_e9_sig", 32'(comp_a), 0);
        tick();
        chk("wash_e10_sig", 32'(sigs_a()), 32'b00100);
        chk("wash_e10_rem", 32'(rem_a), 0);
        chk("sat_e10_rem", 32'(rem_b), 9);

        // Narrow instance reaches 15 at E0+19 and must stay there.
        for (int i = 0; i < 8; i++) tick();
        chk("sat_e18_rem", 32'(rem_b), 1);
        chk("sat_e18_sig", 32'(comp_b), 0);
        tick();
        chk("sat_e19_sig", 32'(comp_b), 1);
        chk("sat_e19_rem", 32'(rem_b), 0);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold_rem", 32'(rem_b), 0);
        chk("sat_hold_busy", 32'(busy_b), 0);
        chk("sat_hold_sig", 32'(comp_b), 1);
        chk("wash_hold_sig", 32'(sigs_a()), 32'b00100);

        // Rinse aborted at cnt=1 by a move to spin.
        state = 3'd5;
        tick();
        chk("rinse_e0_rem", 32'(rem_a), 3);
        chk("rinse_e0_sig", 32'(sigs_a()), 0);
        tick();
        chk("rinse_e1_rem", 32'(rem_a), 2);
        state = 3'd6;
        tick();
        chk("spin_e0_rem", 32'(rem_a), 3);
        tick(); tick();
        chk("spin_e2_rem", 32'(rem_a), 1);
        chk("spin_e2_sig", 32'(sigs_a()), 0);
        tick();
        chk("spin_e3_sig", 32'(sigs_a()), 32'b10000);

        // Asynchronous reset mid-wash at cnt=4.
        state = 3'd4;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_pre_rem", 32'(rem_a), 2);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_all", {sigs_a(), rem_a, busy_a}, 0);
        reset_n = 1'b1;
        tick();
        chk("rst_entry_rem", 32'(rem_a), 6);
        for (int i = 0; i < 5; i++) tick();
        chk("rst_e5_sig", 32'(comp_a), 0);
        chk("rst_e5_rem", 32'(rem_a), 1);
        tick();
        chk("rst_e6_sig", 32'(sigs_a()), 32'b00100);

        // Non-timed states hold everything at zero.
        state = 3'd7;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("state7_all", {sigs_a(), rem_a, busy_a}, 0);
        end
        state = 3'd1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("state1_all", {sigs_a(), rem_a, busy_a}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wash_phase_timer.md
WASH_PHASE_TIMER -- requirements
Module: wash_phase_timer

Interface
REQ-001 SHALL provide parameter CNT_WIDTH, default 8, width of phase counter and remaining output.
REQ-002 SHALL provide parameters FILL_CYCLES=3, HEAT_CYCLES=3, WASH_CYCLES=6, RINSE_CYCLES=3, SPIN_CYCLES=3, the duration of each timed phase in clock cycles.
REQ-003 SHALL provide parameters STATE_FILL_WATER=3'd2, STATE_HEAT_WATER=3'd3, STATE_WASH=3'd4, STATE_RINSE=3'd5, STATE_SPIN=3'd6, the state encodings of the timed phases.
REQ-004 clock  input  1  single rising-edge clock for all sequential logic.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 state  input  3  current controller state.
REQ-007 pause  input  1  high freezes the phase counter (door open or user pause).
REQ-008 sig_Full  output  1  fill phase elapsed.
REQ-009 sig_Temperature  output  1  heat phase elapsed.
REQ-010 sig_Completed  output  1  wash phase elapsed.
REQ-011 sig_Rinsed  output  1  rinse phase elapsed.
REQ-012 sig_Spun  output  1  spin phase elapsed.
REQ-013 remaining  output  CNT_WIDTH  cycles left in the current timed phase.
REQ-014 busy  output  1  high while a timed phase is counting and not yet elapsed.

Function
REQ-015 SHALL register state into state_q each clock; entry = (state != state_q).
REQ-016 On entry, SHALL clear cnt to 0 and clear all five sig_* outputs, regardless of pause.
REQ-017 When not entry, state_q is a timed phase, pause=0 and cnt < DUR(state_q), SHALL increment cnt by 1.
REQ-018 cnt SHALL saturate at DUR; no wrap-around.
REQ-019 The sig_* output of the current phase SHALL be set, registered, on the edge at which cnt becomes DUR, and SHALL hold while state is unchanged.
REQ-020 Latency: with state changed before edge E0 and pause=0, the phase output SHALL go high after edge E0+DUR.
REQ-021 pause=1 SHALL freeze cnt and leave all outputs unchanged; each paused cycle extends the phase by one cycle.
REQ-022 A change to any other state mid-phase SHALL abort the phase; re-entering the phase restarts counting from 0.
REQ-023 Non-timed states (0, 1, 7, and any value not matching REQ-003) SHALL hold cnt=0, all sig_*=0, remaining=0, busy=0.
REQ-024 remaining SHALL equal DUR(state_q)-cnt in a timed phase with no entry pending, and 0 otherwise.
REQ-025 busy SHALL equal (timed phase) AND (cnt < DUR), held high during pause.
REQ-026 At most one sig_* output SHALL be high in any cycle.
REQ-027 Each duration SHALL be >= 1 and <= 2^CNT_WIDTH-1; violation SHALL halt elaboration with an error.

Reset
REQ-028 reset_n=0 SHALL immediately force state_q=3'd0, cnt=0, all sig_*=0, remaining=0 and busy=0, independent of clock.
REQ-029 Reset asserted mid-phase SHALL discard progress; if state is a timed phase at reset release, the first edge is an entry and counting restarts from 0.
REQ-030 Release of reset_n SHALL be synchronised by the integrating system; the block adds no synchroniser.

Verification
REQ-031 state=2 from idle, pause=0 -> sig_Full=0 for edges E0..E0+2; sig_Full=1 after E0+3; remaining sequence 3,2,1,0.
REQ-032 state=4, pause=1 for 4 cycles mid-phase -> cnt frozen, sig_Completed rises after E0+10, busy=1 throughout the pause.
REQ-033 state 5->6 at cnt=1 -> sig_Rinsed never asserts; cnt cleared; sig_Spun high after 3 unpaused edges.
REQ-034 reset_n pulsed low between clock edges during wash at cnt=4 -> all outputs 0 immediately; after release with state=4, 6 further edges are required before sig_Completed=1.
REQ-035 state=7 and state=1 held for 20 cycles -> all sig_*=0, remaining=0, busy=0.
REQ-036 CNT_WIDTH=4 with WASH_CYCLES=15 -> saturates at 15 with no wrap; WASH_CYCLES=16 -> elaboration error.
